// File: rtl/decode_sb.sv
`default_nettype none
// ============================================================================
// Module      : decode_sb
// Description : Instruction decode stage with an 8-entry register file,
//               same-cycle writeback bypass, and a load-use scoreboard that
//               stalls dependent instructions while a load is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_sb #(
    parameter int WIDTH    = 16,
    parameter int LOAD_LAT = 1,
    parameter int RET_REG  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [15:0]      instr_in,
    input  logic             bubble_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             we,
    input  logic [2:0]       target,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] d_1_out,
    output logic [WIDTH-1:0] d_2_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [2:0]       opcode_out,
    output logic [2:0]       s_1_out,
    output logic [2:0]       s_2_out,
    output logic [2:0]       tgt_out,
    output logic [3:0]       alu_op_out,
    output logic [WIDTH-1:0] imm_out,
    output logic [5:0]       branch_code_out,
    output logic             bubble_out,
    output logic             halt_out,
    output logic             stall,
    output logic [WIDTH-1:0] ret_val
);

    localparam logic [2:0] c_OP_UPPER   = 3'b011;  // imm10 << 6 immediate
    localparam logic [2:0] c_OP_RA_SRC  = 3'b100;  // ra is a source, no target
    localparam logic [2:0] c_OP_LOAD    = 3'b101;
    localparam logic [2:0] c_OP_NO_TGT  = 3'b110;
    localparam logic [2:0] c_OP_HALT    = 3'b111;
    localparam logic [2:0] c_LOAD_LAT   = 3'(LOAD_LAT);
    localparam logic [2:0] c_RET_IDX    = 3'(RET_REG);

    logic [2:0]       w_opcode, w_ra, w_rb, w_rc, w_s1, w_s2;
    logic [3:0]       w_alu_op;
    logic [5:0]       w_branch_code;
    logic [6:0]       w_imm7;
    logic [9:0]       w_imm10;
    logic [WIDTH-1:0] w_imm, w_d1, w_d2;
    logic             w_wr_en, w_s1_busy, w_s2_busy, w_stall, w_issue, w_is_load;

    logic [WIDTH-1:0] r_regs [8];
    logic [2:0]       r_busy [8];

    // Instruction field extraction and source selection
    assign w_opcode      = instr_in[15:13];
    assign w_ra          = instr_in[12:10];
    assign w_rb          = instr_in[9:7];
    assign w_alu_op      = instr_in[6:3];
    assign w_rc          = instr_in[2:0];
    assign w_branch_code = instr_in[12:7];
    assign w_imm7        = instr_in[6:0];
    assign w_imm10       = instr_in[9:0];
    assign w_s1          = w_rb;
    assign w_s2          = (w_opcode == c_OP_RA_SRC) ? w_ra : w_rc;

    // Writes to r0 are discarded, so they must not bypass either
    assign w_wr_en = we && (target != 3'd0);

    // Hazard detection uses the counters as they stand before this edge's update
    assign w_s1_busy = (w_s1 != 3'd0) && (r_busy[w_s1] != 3'd0);
    assign w_s2_busy = (w_s2 != 3'd0) && (r_busy[w_s2] != 3'd0);
    assign w_stall   = !bubble_in && !flush && (w_s1_busy || w_s2_busy);
    assign w_issue   = !bubble_in && !flush && !w_stall;
    assign w_is_load = (w_opcode == c_OP_LOAD) && (w_ra != 3'd0);

    assign stall   = w_stall;
    assign ret_val = r_regs[c_RET_IDX];

    // Immediate generation: upper-immediate form zero-extends, all else sign-extends imm7
    always_comb begin
        w_imm = {{(WIDTH-7){w_imm7[6]}}, w_imm7};
        if (w_opcode == c_OP_UPPER) begin
            w_imm        = '0;
            w_imm[15:0]  = {w_imm10, 6'b000000};
        end
    end

    // Register read ports with same-cycle writeback bypass; r0 reads as zero
    always_comb begin
        w_d1 = r_regs[w_s1];
        if (w_s1 == 3'd0) begin
            w_d1 = '0;
        end else if (w_wr_en && (target == w_s1)) begin
            w_d1 = write_data;
        end
        w_d2 = r_regs[w_s2];
        if (w_s2 == 3'd0) begin
            w_d2 = '0;
        end else if (w_wr_en && (target == w_s2)) begin
            w_d2 = write_data;
        end
    end

    // Register file write port; r0 is never written and stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[target] <= write_data;
        end
    end

    // Load scoreboard: an issuing load reloads its target, all others count down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_busy[i] <= 3'd0;
            end
        end else begin
            for (int i = 1; i < 8; i++) begin
                if (w_issue && w_is_load && (w_ra == 3'(i))) begin
                    r_busy[i] <= c_LOAD_LAT;
                end else if (r_busy[i] != 3'd0) begin
                    r_busy[i] <= r_busy[i] - 3'd1;
                end
            end
        end
    end

    // Decode pipeline register; control outputs are squashed unless the instruction issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_1_out         <= '0;
            d_2_out         <= '0;
            pc_out          <= '0;
            opcode_out      <= 3'd0;
            s_1_out         <= 3'd0;
            s_2_out         <= 3'd0;
            tgt_out         <= 3'd0;
            alu_op_out      <= 4'd0;
            imm_out         <= '0;
            branch_code_out <= 6'd0;
            bubble_out      <= 1'b1;
            halt_out        <= 1'b0;
        end else begin
            d_1_out         <= w_d1;
            d_2_out         <= w_d2;
            pc_out          <= pc_in;
            opcode_out      <= w_opcode;
            s_1_out         <= w_s1;
            s_2_out         <= w_s2;
            alu_op_out      <= w_alu_op;
            imm_out         <= w_imm;
            branch_code_out <= w_branch_code;
            bubble_out      <= (flush || w_stall) ? 1'b1 : bubble_in;
            tgt_out         <= (!w_issue || (w_opcode == c_OP_RA_SRC) || (w_opcode == c_OP_NO_TGT))
                               ? 3'd0 : w_ra;
            halt_out        <= w_issue && (w_opcode == c_OP_HALT) && (w_imm7 != 7'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_sb
// Description : Self-checking bench for decode_sb. Instance A is 16-bit with
//               a one-cycle load latency, instance B is 32-bit with a
//               three-cycle load latency; both share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_sb;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] instr_in;
    logic        bubble_in;
    logic [31:0] pc_in;
    logic        we;
    logic [2:0]  target;
    logic [31:0] write_data;

    logic [15:0] a_d1, a_d2, a_pc, a_imm, a_ret;
    logic [2:0]  a_op, a_s1, a_s2, a_tgt;
    logic [3:0]  a_alu;
    logic [5:0]  a_bc;
    logic        a_bub, a_halt, a_stall;

    logic [31:0] b_d1, b_d2, b_pc, b_imm, b_ret;
    logic [2:0]  b_op, b_s1, b_s2, b_tgt;
    logic [3:0]  b_alu;
    logic [5:0]  b_bc;
    logic        b_bub, b_halt, b_stall;

    typedef struct packed {
        logic [2:0]  tgt;
        logic        bub;
        logic        halt;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    decode_sb #(.WIDTH(16), .LOAD_LAT(1), .RET_REG(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .instr_in(instr_in),
        .bubble_in(bubble_in), .pc_in(pc_in[15:0]), .we(we), .target(target),
        .write_data(write_data[15:0]),
        .d_1_out(a_d1), .d_2_out(a_d2), .pc_out(a_pc), .opcode_out(a_op),
        .s_1_out(a_s1), .s_2_out(a_s2), .tgt_out(a_tgt), .alu_op_out(a_alu),
        .imm_out(a_imm), .branch_code_out(a_bc), .bubble_out(a_bub),
        .halt_out(a_halt), .stall(a_stall), .ret_val(a_ret)
    );

    decode_sb #(.WIDTH(32), .LOAD_LAT(3), .RET_REG(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .instr_in(instr_in),
        .bubble_in(bubble_in), .pc_in(pc_in), .we(we), .target(target),
        .write_data(write_data),
        .d_1_out(b_d1), .d_2_out(b_d2), .pc_out(b_pc), .opcode_out(b_op),
        .s_1_out(b_s1), .s_2_out(b_s2), .tgt_out(b_tgt), .alu_op_out(b_alu),
        .imm_out(b_imm), .branch_code_out(b_bc), .bubble_out(b_bub),
        .halt_out(b_halt), .stall(b_stall), .ret_val(b_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [3:0] alu,
                                        input logic [2:0] rc);
        return {op, ra, rb, alu, rc};
    endfunction

    task automatic drive(input logic [15:0] ins, input logic bub, input logic fl);
        instr_in  = ins;
        bubble_in = bub;
        flush     = fl;
        we        = 1'b0;
        target    = 3'd0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(16'h0000, 1'b1, 1'b0);
        repeat (n) tick();
    endtask

    task automatic test_reset;
        #3;
        drive(enc(3'd0, 3'd5, 3'd3, 4'd0, 3'd3), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if (a_bub !== 1'b1) begin bad++; $display("FAIL rst_bubble actual=%0b required=1", a_bub); end
        total++; if (a_tgt !== 3'd0) begin bad++; $display("FAIL rst_tgt actual=%0d required=0", a_tgt); end
        total++; if (a_halt !== 1'b0) begin bad++; $display("FAIL rst_halt actual=%0b required=0", a_halt); end
        total++; if (a_ret !== 16'h0) begin bad++; $display("FAIL rst_ret_val actual=%h required=0", a_ret); end
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL rst_stall actual=%0b required=0", a_stall); end
        total++; if (b_bub !== 1'b1) begin bad++; $display("FAIL rst_bubble_b actual=%0b required=1", b_bub); end
        tick(); tick();
        rst_n = 1'b1;
        // reset asserted while a dependent instruction is stalled
        drive(enc(3'b101, 3'd3, 3'd0, 4'd0, 3'd0), 1'b0, 1'b0);
        tick();
        drive(enc(3'd0, 3'd5, 3'd3, 4'd0, 3'd0), 1'b0, 1'b0);
        #1;
        total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL pre_rst_stall actual=%0b required=1", a_stall); end
        rst_n = 1'b0;
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL mid_rst_stall actual=%0b required=0", a_stall); end
        total++; if (a_bub !== 1'b1) begin bad++; $display("FAIL mid_rst_bubble actual=%0b required=1", a_bub); end
        tick();
        rst_n = 1'b1;
        sb.push_back(exp_t'{tgt: 3'd5, bub: 1'b0, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_tgt !== e.tgt || a_bub !== e.bub) begin bad++; $display("FAIL post_rst_issue tgt=%0d bub=%0b required tgt=%0d bub=%0b", a_tgt, a_bub, e.tgt, e.bub); end
    endtask

    task automatic test_load_use(input bit use_b);
        int         lat;
        logic       ost;
        logic [2:0] otgt;
        logic       obub;
        logic [31:0] opc;
        lat = use_b ? 3 : 1;
        idle(5);
        // independent instruction directly behind a load
        drive(enc(3'b101, 3'd3, 3'd0, 4'd0, 3'd0), 1'b0, 1'b0);
        pc_in = 32'h0000_0100;
        sb.push_back(exp_t'{tgt: 3'd3, bub: 1'b0, halt: 1'b0, val: 32'h0000_0100});
        tick();
        e = sb.pop_front();
        otgt = use_b ? b_tgt : a_tgt;
        opc  = use_b ? b_pc : {16'h0, a_pc};
        total++; if (otgt !== e.tgt) begin bad++; $display("FAIL lu%0d_load_tgt actual=%0d required=%0d", lat, otgt, e.tgt); end
        total++; if (opc !== e.val) begin bad++; $display("FAIL lu%0d_pc actual=%h required=%h", lat, opc, e.val); end
        drive(enc(3'd0, 3'd5, 3'd2, 4'd0, 3'd1), 1'b0, 1'b0);
        #1;
        ost = use_b ? b_stall : a_stall;
        total++; if (ost !== 1'b0) begin bad++; $display("FAIL lu%0d_indep_stall actual=%0b required=0", lat, ost); end
        sb.push_back(exp_t'{tgt: 3'd5, bub: 1'b0, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        otgt = use_b ? b_tgt : a_tgt;
        total++; if (otgt !== e.tgt) begin bad++; $display("FAIL lu%0d_indep_tgt actual=%0d required=%0d", lat, otgt, e.tgt); end
        idle(5);
        // dependent instruction directly behind a load: held exactly lat cycles
        drive(enc(3'b101, 3'd3, 3'd0, 4'd0, 3'd0), 1'b0, 1'b0);
        tick();
        drive(enc(3'd0, 3'd5, 3'd3, 4'd0, 3'd0), 1'b0, 1'b0);
        for (int k = 0; k <= lat; k++) begin
            #1;
            ost = use_b ? b_stall : a_stall;
            total++; if (ost !== (k < lat)) begin bad++; $display("FAIL lu%0d_stall_c%0d actual=%0b required=%0b", lat, k, ost, (k < lat)); end
            sb.push_back(exp_t'{tgt: (k < lat) ? 3'd0 : 3'd5, bub: (k < lat), halt: 1'b0, val: 32'h0});
            tick();
            e = sb.pop_front();
            otgt = use_b ? b_tgt : a_tgt;
            obub = use_b ? b_bub : a_bub;
            total++; if (otgt !== e.tgt || obub !== e.bub) begin bad++; $display("FAIL lu%0d_out_c%0d tgt=%0d bub=%0b required tgt=%0d bub=%0b", lat, k, otgt, obub, e.tgt, e.bub); end
        end
    endtask

    task automatic test_bypass;
        idle(5);
        drive(enc(3'd0, 3'd4, 3'd2, 4'd0, 3'd0), 1'b0, 1'b0);
        we = 1'b1; target = 3'd2; write_data = 32'h0000_BEEF;
        sb.push_back(exp_t'{tgt: 3'd4, bub: 1'b0, halt: 1'b0, val: 32'h0000_BEEF});
        tick();
        e = sb.pop_front();
        total++; if (a_d1 !== e.val[15:0]) begin bad++; $display("FAIL byp_d1 actual=%h required=%h", a_d1, e.val[15:0]); end
        // stored value read back through the second port
        drive(enc(3'd0, 3'd4, 3'd0, 4'd0, 3'd2), 1'b0, 1'b0);
        sb.push_back(exp_t'{tgt: 3'd4, bub: 1'b0, halt: 1'b0, val: 32'h0000_BEEF});
        tick();
        e = sb.pop_front();
        total++; if (a_d2 !== e.val[15:0]) begin bad++; $display("FAIL rf_d2 actual=%h required=%h", a_d2, e.val[15:0]); end
        // write to r0 while both ports read r0
        drive(enc(3'd0, 3'd4, 3'd0, 4'd0, 3'd0), 1'b0, 1'b0);
        we = 1'b1; target = 3'd0; write_data = 32'h0000_1234;
        sb.push_back(exp_t'{tgt: 3'd4, bub: 1'b0, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_d1 !== e.val[15:0]) begin bad++; $display("FAIL r0_d1 actual=%h required=%h", a_d1, e.val[15:0]); end
        total++; if (a_d2 !== e.val[15:0]) begin bad++; $display("FAIL r0_d2 actual=%h required=%h", a_d2, e.val[15:0]); end
        drive(16'h0000, 1'b1, 1'b0);
        we = 1'b1; target = 3'd1; write_data = 32'h0000_5A5A;
        tick();
        we = 1'b0;
        total++; if (a_ret !== 16'h5A5A) begin bad++; $display("FAIL ret_val_a actual=%h required=5a5a", a_ret); end
        total++; if (b_ret !== 32'h0000_BEEF) begin bad++; $display("FAIL ret_val_b actual=%h required=0000beef", b_ret); end
    endtask

    task automatic test_imm;
        idle(2);
        drive(16'h0040, 1'b0, 1'b0);
        sb.push_back(exp_t'{tgt: 3'd0, bub: 1'b0, halt: 1'b0, val: 32'hFFFF_FFC0});
        tick();
        e = sb.pop_front();
        total++; if (b_imm !== e.val) begin bad++; $display("FAIL imm7_neg_b actual=%h required=%h", b_imm, e.val); end
        total++; if (a_imm !== e.val[15:0]) begin bad++; $display("FAIL imm7_neg_a actual=%h required=%h", a_imm, e.val[15:0]); end
        drive(16'h63FF, 1'b0, 1'b0);
        sb.push_back(exp_t'{tgt: 3'd0, bub: 1'b0, halt: 1'b0, val: 32'h0000_FFC0});
        tick();
        e = sb.pop_front();
        total++; if (b_imm !== e.val) begin bad++; $display("FAIL imm10_b actual=%h required=%h", b_imm, e.val); end
        total++; if (a_imm !== e.val[15:0]) begin bad++; $display("FAIL imm10_a actual=%h required=%h", a_imm, e.val[15:0]); end
        drive(16'h003F, 1'b0, 1'b0);
        sb.push_back(exp_t'{tgt: 3'd0, bub: 1'b0, halt: 1'b0, val: 32'h0000_003F});
        tick();
        e = sb.pop_front();
        total++; if (b_imm !== e.val) begin bad++; $display("FAIL imm7_pos_b actual=%h required=%h", b_imm, e.val); end
    endtask

    task automatic test_flush_halt;
        idle(5);
        drive(16'hE801, 1'b0, 1'b1);
        sb.push_back(exp_t'{tgt: 3'd0, bub: 1'b1, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_halt !== e.halt || a_bub !== e.bub || a_tgt !== e.tgt) begin bad++; $display("FAIL flush_halt halt=%0b bub=%0b tgt=%0d required halt=%0b bub=%0b tgt=%0d", a_halt, a_bub, a_tgt, e.halt, e.bub, e.tgt); end
        drive(16'hE801, 1'b0, 1'b0);
        sb.push_back(exp_t'{tgt: 3'd2, bub: 1'b0, halt: 1'b1, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_halt !== e.halt || a_tgt !== e.tgt) begin bad++; $display("FAIL halt halt=%0b tgt=%0d required halt=%0b tgt=%0d", a_halt, a_tgt, e.halt, e.tgt); end
        drive(16'hE800, 1'b0, 1'b0);
        sb.push_back(exp_t'{tgt: 3'd2, bub: 1'b0, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_halt !== e.halt) begin bad++; $display("FAIL halt_imm0 actual=%0b required=%0b", a_halt, e.halt); end
        // a flushed load must not mark its target busy
        drive(enc(3'b101, 3'd3, 3'd0, 4'd0, 3'd0), 1'b0, 1'b1);
        sb.push_back(exp_t'{tgt: 3'd0, bub: 1'b1, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_tgt !== e.tgt || a_bub !== e.bub) begin bad++; $display("FAIL flush_load tgt=%0d bub=%0b required tgt=%0d bub=%0b", a_tgt, a_bub, e.tgt, e.bub); end
        drive(enc(3'd0, 3'd5, 3'd3, 4'd0, 3'd0), 1'b0, 1'b0);
        #1;
        total++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin bad++; $display("FAIL flush_load_dep_stall a=%0b b=%0b required 0", a_stall, b_stall); end
        sb.push_back(exp_t'{tgt: 3'd5, bub: 1'b0, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_tgt !== e.tgt) begin bad++; $display("FAIL flush_load_dep_tgt actual=%0d required=%0d", a_tgt, e.tgt); end
        // flush does not clear an in-flight load (three-cycle instance)
        idle(4);
        drive(enc(3'b101, 3'd3, 3'd0, 4'd0, 3'd0), 1'b0, 1'b0);
        tick();
        drive(enc(3'd0, 3'd5, 3'd3, 4'd0, 3'd0), 1'b0, 1'b1);
        tick();
        drive(enc(3'd0, 3'd5, 3'd3, 4'd0, 3'd0), 1'b0, 1'b0);
        we = 1'b1; target = 3'd3; write_data = 32'h0000_0077;
        #1;
        total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL flush_keeps_busy actual=%0b required=1", b_stall); end
        tick();
        we = 1'b0;
    endtask

    task automatic test_back_to_back;
        idle(5);
        // load whose own source is its target checks the pre-update counter
        drive(enc(3'b101, 3'd3, 3'd3, 4'd0, 3'd0), 1'b0, 1'b0);
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL self_load_stall actual=%0b required=0", a_stall); end
        sb.push_back(exp_t'{tgt: 3'd3, bub: 1'b0, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_tgt !== e.tgt) begin bad++; $display("FAIL self_load_tgt actual=%0d required=%0d", a_tgt, e.tgt); end
        #1;
        total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL b2b_load_stall actual=%0b required=1", a_stall); end
        tick();
        // opcode 100 reads ra as a source and produces no target
        idle(3);
        drive(enc(3'b101, 3'd4, 3'd0, 4'd0, 3'd0), 1'b0, 1'b0);
        tick();
        drive(enc(3'b100, 3'd4, 3'd1, 4'd0, 3'd0), 1'b0, 1'b0);
        #1;
        total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL op100_ra_stall actual=%0b required=1", a_stall); end
        sb.push_back(exp_t'{tgt: 3'd0, bub: 1'b1, halt: 1'b0, val: 32'h0});
        sb.push_back(exp_t'{tgt: 3'd0, bub: 1'b0, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_bub !== e.bub) begin bad++; $display("FAIL op100_bubble actual=%0b required=%0b", a_bub, e.bub); end
        tick();
        e = sb.pop_front();
        total++; if (a_bub !== e.bub || a_tgt !== e.tgt) begin bad++; $display("FAIL op100_issue bub=%0b tgt=%0d required bub=%0b tgt=%0d", a_bub, a_tgt, e.bub, e.tgt); end
        drive(enc(3'b110, 3'd5, 3'd0, 4'd0, 3'd0), 1'b0, 1'b0);
        sb.push_back(exp_t'{tgt: 3'd0, bub: 1'b0, halt: 1'b0, val: 32'h0});
        tick();
        e = sb.pop_front();
        total++; if (a_tgt !== e.tgt || a_bub !== e.bub) begin bad++; $display("FAIL op110 tgt=%0d bub=%0b required tgt=%0d bub=%0b", a_tgt, a_bub, e.tgt, e.bub); end
    endtask

    initial begin
        rst_n      = 1'b1;
        pc_in      = 32'h0;
        write_data = 32'h0;
        drive(16'h0000, 1'b1, 1'b0);
        test_reset();
        test_load_use(1'b0);
        test_load_use(1'b1);
        test_bypass();
        test_imm();
        test_flush_halt();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/decode_sb.md
DECODE_SB -- requirements
Module: decode_sb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, register/data width; legal values are 16 to 64.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, cycles a load target stays busy after issue; legal values are 1 to 4.
REQ-003 The block SHALL have parameter RET_REG, default 1, index of the register mirrored on ret_val; legal values are 1 to 7.
REQ-004 Port list: clk input 1, sole clock, all state on rising edge.
REQ-005 Port list: rst_n input 1, asynchronous active-low reset.
REQ-006 Port list: flush input 1, squash the instruction in decode.
REQ-007 Port list: instr_in input 16, fetched instruction.
REQ-008 Port list: bubble_in input 1, instr_in is invalid.
REQ-009 Port list: pc_in input WIDTH, PC of instr_in.
REQ-010 Port list: we input 1, writeback enable.
REQ-011 Port list: target input 3, writeback register index.
REQ-012 Port list: write_data input WIDTH, writeback value.
REQ-013 Port list, registered outputs: d_1_out WIDTH, d_2_out WIDTH, pc_out WIDTH, opcode_out 3, s_1_out 3, s_2_out 3, tgt_out 3, alu_op_out 4, imm_out WIDTH, branch_code_out 6, bubble_out 1, halt_out 1.
REQ-014 Port list, combinational outputs: stall output 1, hold upstream; ret_val output WIDTH, current value of register RET_REG.

Function
REQ-015 The decoder SHALL split instr_in into these fields: opcode=[15:13], ra=[12:10], rb=[9:7], alu_op=[6:3], rc=[2:0], branch_code=[12:7], imm7=[6:0], imm10=[9:0].
REQ-016 Sources SHALL be s_1=rb, with s_2=ra for opcode 100 and s_2=rc otherwise.
REQ-017 The immediate SHALL be imm10 followed by six zero bits, zero-extended to WIDTH, for opcode 011; for all other opcodes it SHALL be imm7 sign-extended to WIDTH.
REQ-018 The block SHALL contain an internal register file of 8 x WIDTH with 2 read ports and 1 write port.
REQ-019 The register file SHALL perform its write at the clock edge when we=1 and target!=0.
REQ-020 Register r0 SHALL always read 0.
REQ-021 Read bypass: when we=1, target!=0 and target equals a source index, that source read SHALL return write_data in the same cycle.
REQ-022 The block SHALL keep one 3-bit busy counter per register in a scoreboard, covering r1..r7.
REQ-023 issue SHALL be defined as !bubble_in && !flush && !stall.
REQ-024 A load is opcode 101 with ra!=0.
REQ-025 When a load issues, busy[ra] SHALL be set to LOAD_LAT, overriding any nonzero value.
REQ-026 Every other nonzero busy counter SHALL decrement by 1 each cycle, saturating at 0.
REQ-027 stall SHALL equal !bubble_in && !flush && ((s_1!=0 && busy[s_1]!=0) || (s_2!=0 && busy[s_2]!=0)).
REQ-028 The stall check SHALL apply to both sources regardless of opcode.
REQ-029 During stall the block SHALL not latch instr_in; upstream holds instr_in and pc_in stable.
REQ-030 Each edge, the pipeline register SHALL load opcode, s_1, s_2, alu_op, imm, branch_code, pc_in, d_1 and d_2 unconditionally.
REQ-031 bubble_out SHALL be set to 1 if flush or stall, else to bubble_in.
REQ-032 tgt_out SHALL be set to 0 if !issue or opcode is 100 or 110, else to ra.
REQ-033 halt_out SHALL be set to 1 only if issue, opcode=111 and imm7!=0.
REQ-034 Latency: an issued instruction SHALL appear on the outputs 1 cycle after it is presented.
REQ-035 A stalled instruction SHALL issue in the first cycle where its sources are not busy.
REQ-036 With LOAD_LAT=L, a dependent instruction directly behind a load SHALL be held for exactly L stall cycles.
REQ-037 Flush SHALL not clear the scoreboard, because loads already issued remain in flight.
REQ-038 A writeback to a busy register SHALL not clear its busy counter.
REQ-039 A load whose ra is also its own source SHALL be checked against the counters held before the update.

Reset
REQ-040 While rst_n=0, all 8 registers, all busy counters and all registered outputs SHALL be 0, except bubble_out, which SHALL be 1.
REQ-041 The reset values SHALL take effect immediately on assertion, without waiting for clk.
REQ-042 Reset asserted mid-stall SHALL drop stall within the same cycle because all busy counters are 0.
REQ-043 The first edge after rst_n rises SHALL process instr_in normally.

Verification
REQ-044 Reset scenario: with rst_n=0 the bench SHALL check bubble_out=1, tgt_out=0, halt_out=0, ret_val=0 and stall=0, including when instr_in is a dependent instruction.
REQ-045 Load-use scenario, LOAD_LAT=1: load to r3, then add with rb=3 -> stall=1 for exactly 1 cycle, one bubble on bubble_out, then the add issues with tgt_out=ra.
REQ-046 Load-use scenario, LOAD_LAT=3: the same sequence -> stall=1 for 3 consecutive cycles; an independent instruction behind the load -> no stall.
REQ-047 Bypass scenario: we=1, target=2, write_data=16'hBEEF while the decoded instruction reads r2 -> d_1_out=16'hBEEF on the next edge; a write with target=0 -> d reads 0.
REQ-048 Immediate scenario, WIDTH=32: imm7=7'h40 -> imm_out=32'hFFFFFFC0; opcode 011 with imm10=10'h3FF -> imm_out=32'h0000FFC0.
REQ-049 Flush/halt scenario: flush=1 with a halt instruction (opcode 111, imm7=1) -> halt_out=0, bubble_out=1, tgt_out=0; flush with a load -> no busy counter set and the next dependent instruction does not stall.
